// File: rtl/pm_min_scheduler.sv
// Minimum path-metric search over all trellis states using one shared compare
// tree, time-multiplexed across two slices with a final modular compare.
module pm_min_scheduler #(
    parameter int unsigned PM_W     = 8,
    parameter int unsigned N_STATES = 64,
    parameter int unsigned SLICE_N  = 32,
    parameter int unsigned IDX_W    = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     pm_valid,
    output logic                     pm_ready,
    input  logic [N_STATES*PM_W-1:0] pm_data,
    output logic                     min_valid,
    input  logic                     min_ready,
    output logic [PM_W-1:0]          min_value,
    output logic [IDX_W-1:0]         min_index,
    output logic                     busy
);

    localparam int unsigned TREE_W = $clog2(SLICE_N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_S0   = 2'd1;
    localparam logic [1:0] ST_S1   = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]                 state;
    logic [1:0]                 state_next;
    logic                       min_valid_next;
    logic                       accept_c;
    logic                       load_best0_c;
    logic                       load_min_c;

    logic [N_STATES*PM_W-1:0]   pm_buf;
    logic [PM_W-1:0]            best0_value;
    logic [TREE_W-1:0]          best0_index;

    logic [PM_W-1:0]            tree_value;
    logic [TREE_W-1:0]          tree_index;
    logic [PM_W-1:0]            final_value;
    logic [IDX_W-1:0]           final_index;

    // Modular compare: X1 wins iff it is strictly older after wrap; ties go to X2.
    function automatic logic x1_wins(input logic [PM_W-1:0] x1, input logic [PM_W-1:0] x2);
        return x1[PM_W-1] ^ x2[PM_W-1] ^ (x1[PM_W-2:0] < x2[PM_W-2:0]);
    endfunction

    // Shared pairwise tree; node i keeps the lower-index operand, i+step the higher.
    always_comb begin : tree_reduce
        logic [PM_W-1:0]   tv [SLICE_N];
        logic [TREE_W-1:0] ti [SLICE_N];
        for (int i = 0; i < SLICE_N; i++) begin
            if (state == ST_S1) begin
                tv[i] = pm_buf[(SLICE_N + i)*PM_W +: PM_W];
            end else begin
                tv[i] = pm_buf[i*PM_W +: PM_W];
            end
            ti[i] = TREE_W'(i);
        end
        for (int step = 1; step < SLICE_N; step = step * 2) begin
            for (int i = 0; i < SLICE_N; i = i + 2*step) begin
                if (!x1_wins(tv[i], tv[i+step])) begin
                    tv[i] = tv[i+step];
                    ti[i] = ti[i+step];
                end
            end
        end
        tree_value = tv[0];
        tree_index = ti[0];
    end

    // Final compare between the slice-0 best and the slice-1 winner.
    always_comb begin
        final_value = tree_value;
        final_index = IDX_W'(SLICE_N) + IDX_W'(tree_index);
        if (x1_wins(best0_value, tree_value)) begin
            final_value = best0_value;
            final_index = IDX_W'(best0_index);
        end
    end

    always_comb begin
        state_next     = state;
        min_valid_next = min_valid;
        accept_c       = 1'b0;
        load_best0_c   = 1'b0;
        load_min_c     = 1'b0;
        if (flush) begin
            state_next     = ST_IDLE;
            min_valid_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pm_valid) begin
                        accept_c   = 1'b1;
                        state_next = ST_S0;
                    end
                end
                ST_S0: begin
                    load_best0_c = 1'b1;
                    state_next   = ST_S1;
                end
                ST_S1: begin
                    load_min_c     = 1'b1;
                    min_valid_next = 1'b1;
                    state_next     = ST_OUT;
                end
                ST_OUT: begin
                    if (min_ready) begin
                        min_valid_next = 1'b0;
                        state_next     = ST_IDLE;
                    end
                end
                default: begin
                    state_next     = ST_IDLE;
                    min_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pm_ready  <= 1'b1;
            busy      <= 1'b0;
            min_valid <= 1'b0;
        end else begin
            state     <= state_next;
            pm_ready  <= (state_next == ST_IDLE);
            busy      <= (state_next != ST_IDLE);
            min_valid <= min_valid_next;
        end
    end

    // Metric buffer, slice-0 best and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_buf      <= '0;
            best0_value <= '0;
            best0_index <= '0;
            min_value   <= '0;
            min_index   <= '0;
        end else begin
            if (accept_c) begin
                pm_buf <= pm_data;
            end
            if (load_best0_c) begin
                best0_value <= tree_value;
                best0_index <= tree_index;
            end
            if (load_min_c) begin
                min_value <= final_value;
                min_index <= final_index;
            end
        end
    end

endmodule

// File: doc/pm_min_scheduler.md
Name: pm_min_scheduler

Overview:
- Finds the minimum path metric and its state index over all 64 trellis states, using one shared 32-input compare tree over two consecutive cycles (slice 0, then slice 1).
- Sits between the ACS/path-metric register bank and traceback start and PM normalization logic.
- Valid/ready handshake on both sides.
- The compare is wrap-around (modular): A wins over B iff A[MSB]^B[MSB]^(A[MSB-1:0] < B[MSB-1:0]).

Parameters:
PM_W, 8, path-metric width in bits (modular compare; metric spread across states must stay < 2^(PM_W-1))
N_STATES, 64, total states; fixed at 2*SLICE_N
SLICE_N, 32, inputs to the shared compare tree (power of 2)
IDX_W, 6, state-index width, log2(N_STATES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; returns to IDLE, drops any pending result
pm_valid  in  1  pm_data holds a full metric vector
pm_ready  out  1  block can accept a vector
pm_data  in  N_STATES*PM_W  metric of state s at bits [s*PM_W+PM_W-1 : s*PM_W]
min_valid  out  1  result valid
min_ready  in  1  consumer accepts result
min_value  out  PM_W  minimum metric
min_index  out  IDX_W  state index of minimum (0..63)
busy  out  1  high in S0, S1, OUT

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pm_ready=1, min_valid=0, min_value=0, min_index=0, busy=0.
  - Internal buffer and best-of-slice-0 registers cleared to 0.
- Clock and reset: one clock domain (clk); reset is asynchronous and active-low (rst_n).
- FSM states: IDLE, S0, S1, OUT.
  - pm_ready = (state==IDLE), decoded from registered state.
  - busy = !IDLE.
- IDLE: on pm_valid&pm_ready, capture all of pm_data into pm_buf and go to S0. pm_data may change afterwards.
- S0:
  - Tree input = pm_buf slice 0 (states 0..31).
  - Register best0_value and best0_index (tree position 0..31). Go to S1.
- S1:
  - Tree input = pm_buf slice 1 (states 32..63). Candidate index = 32 + tree position.
  - Final compare: X1 = best0, X2 = slice-1 winner.
  - Register min_value and min_index, set min_valid=1, go to OUT.
- OUT:
  - Outputs held stable while min_valid & !min_ready.
  - On min_ready: min_valid=0, go to IDLE. min_value and min_index keep their last value.
- Latency and throughput:
  - Accept edge E0, then min_valid high after edge E2 (2 cycles).
  - Minimum 4 cycles per vector with min_ready tied high.
- Compare tree:
  - Binary pairwise tree, log2(SLICE_N)=5 levels, combinational within one cycle.
  - Node rule: select X1 (lower index) iff X1[PM_W-1]^X2[PM_W-1]^(X1[PM_W-2:0] < X2[PM_W-2:0]), else X2.
- Tie-break: equal metrics select X2 at every node and in the final compare, so the highest state index among tied minima wins.
- Index: straight binary state number. No reversal or offset remapping.
- flush:
  - Synchronous, highest priority below reset, effective in any state.
  - Next state IDLE, min_valid=0. A pm_valid in the same cycle is not accepted.
  - min_value and min_index retain their old values.
- Reset mid-operation (S0/S1/OUT): immediate return to reset values. The partial result is lost and is not emitted.
- pm_valid while not IDLE: ignored (pm_ready=0). The source must hold the vector.
- min_ready while min_valid=0: no effect.

Test Plan:
- Reset, then vector with all metrics 0x40 except state 17=0x10 -> after 2 cycles min_valid=1, min_value=0x10, min_index=17. pm_ready=0 during S0/S1/OUT, 1 again the cycle after min_ready.
- Minimum in slice 1: state 50=0x05, others 0x20 -> min_index=50, min_value=0x05. Also state 0=0x05 and state 63=0x05 (tie across slices) -> min_index=63.
- Wrap-around: state 3=0x7E, state 40=0x82, others 0x90 -> min_index=3, value 0x7E. Then state 3=0xFE, state 40=0x02, others 0x10 -> min_index=3, value 0xFE (0x02 is newer than 0xFE after wrap).
- Backpressure: hold min_ready=0 for 5 cycles with pm_valid held high and a new vector -> outputs stable, pm_ready=0, second vector accepted only after the min_ready handshake. Its result is correct and independent of the first.
- flush asserted in S1, and separately in OUT -> next cycle IDLE, min_valid=0, no result emitted. A following vector gives the correct result.
- rst_n pulsed low asynchronously mid-S0 -> outputs take reset values without a clock edge. After release, the block accepts a new vector with standard 2-cycle latency.
